// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared constants for the UART transmit arbiter.
//   - State encoding of the arbiter FSM (2-bit, kept as plain localparams so
//     the encoding is fixed and visible in waveforms).
//   - Byte width handed to the UART core.
package uart_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_SEND       = 2'd1;
  localparam state_t ST_WAIT_START = 2'd2;
  localparam state_t ST_WAIT_DONE  = 2'd3;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin selector.
//   req  [NREQ]  : request bits
//   last [IDX_W] : index of the most recent winner
//   any          : at least one request is set
//   idx  [IDX_W] : first set request searching from last+1, wrapping modulo NREQ
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // cand[k] is the requester examined at search position k (k=0 is last+1).
  logic [IDX_W-1:0] cand [NREQ];
  logic [NREQ-1:0]  hit;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      // last < NREQ and gi+1 <= NREQ, so one conditional subtract is enough
      // to wrap; the extra bit keeps the sum from overflowing.
      logic [IDX_W:0] sum;
      assign sum       = {1'b0, last} + (IDX_W+1)'(gi + 1);
      assign cand[gi]  = (sum >= (IDX_W+1)'(NREQ)) ? IDX_W'(sum - (IDX_W+1)'(NREQ))
                                                    : sum[IDX_W-1:0];
      assign hit[gi]   = req[cand[gi]];
    end
  endgenerate

  assign any = |hit;

  // Scan from the far end so the lowest search position wins.
  always_comb begin
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx = cand[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between NREQ word producers. Requesters are
// granted round-robin at word boundaries; the winning N-bit word is latched and
// sent as N/8 bytes, MSB byte first, over the transmit/tx_byte/is_transmitting
// handshake.
//
// Ports
//   iCE_CLK          : system clock
//   rst              : synchronous active-high reset
//   req_valid[NREQ]  : requester i offers req_data[i*N +: N]
//   req_data[NREQ*N] : flattened request words
//   req_ready[NREQ]  : one-cycle pulse when word i is accepted
//   grant[NREQ]      : one-hot owner of the word being sent, 0 when idle
//   is_transmitting  : UART busy flag
//   transmit         : one-cycle start pulse to the UART
//   tx_byte[8]       : byte to the UART, stable until the byte completes
//   busy             : FSM is not idle
//
// Every output is a register or a decode of the state register, so nothing
// combinational reaches the outputs from req_valid or is_transmitting.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N         = 32,
  parameter int Ndiv8log2 = 2,
  parameter int NREQ      = 2
) (
  input  logic              iCE_CLK,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  input  logic              is_transmitting,
  output logic              transmit,
  output logic [7:0]        tx_byte,
  output logic              busy
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BCNT_W = (Ndiv8log2 > 0) ? Ndiv8log2 : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(N / BYTE_W - 1);
  localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NREQ - 1);

  state_t            state_reg,     state_next;
  logic [N-1:0]      shreg_reg,     shreg_next;
  logic [BCNT_W-1:0] bcnt_reg,      bcnt_next;
  logic [IDX_W-1:0]  last_reg,      last_next;
  logic [NREQ-1:0]   grant_reg,     grant_next;
  logic [NREQ-1:0]   req_ready_reg, req_ready_next;
  logic              transmit_reg,  transmit_next;
  logic [7:0]        tx_byte_reg,   tx_byte_next;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic [NREQ-1:0]   pick_onehot;
  logic [N-1:0]      pick_word;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (req_valid),
    .last (last_reg),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    pick_word = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_onehot[k]) begin
        pick_word = req_data[k*N +: N];
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    shreg_next     = shreg_reg;
    bcnt_next      = bcnt_reg;
    last_next      = last_reg;
    grant_next     = grant_reg;
    req_ready_next = '0;
    transmit_next  = 1'b0;
    tx_byte_next   = tx_byte_reg;

    case (state_reg)
      ST_IDLE: begin
        // Waiting for is_transmitting low also covers a reset that landed
        // while a byte was still on the wire.
        if (pick_any && !is_transmitting) begin
          state_next     = ST_SEND;
          shreg_next     = pick_word;
          bcnt_next      = '0;
          grant_next     = pick_onehot;
          last_next      = pick_idx;
          req_ready_next = pick_onehot;
        end
      end
      ST_SEND: begin
        // transmit and tx_byte are registered here, so the pulse is seen in
        // the cycle after SEND, i.e. the first cycle of WAIT_START.
        transmit_next = 1'b1;
        tx_byte_next  = shreg_reg[N-1 -: BYTE_W];
        state_next    = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (is_transmitting) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!is_transmitting) begin
          if (bcnt_reg == BCNT_LAST) begin
            state_next = ST_IDLE;
            grant_next = '0;
          end else begin
            shreg_next = shreg_reg << BYTE_W;
            bcnt_next  = bcnt_reg + 1'b1;
            state_next = ST_SEND;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCE_CLK) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      shreg_reg     <= '0;
      bcnt_reg      <= '0;
      last_reg      <= LAST_INIT;
      grant_reg     <= '0;
      req_ready_reg <= '0;
      transmit_reg  <= 1'b0;
      tx_byte_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      bcnt_reg      <= bcnt_next;
      last_reg      <= last_next;
      grant_reg     <= grant_next;
      req_ready_reg <= req_ready_next;
      transmit_reg  <= transmit_next;
      tx_byte_reg   <= tx_byte_next;
    end
  end

  assign req_ready = req_ready_reg;
  assign grant     = grant_reg;
  assign transmit  = transmit_reg;
  assign tx_byte   = tx_byte_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with a simple UART model (configurable
// byte time and start delay). A negedge monitor logs every transmitted byte
// and every acceptance; the main sequence compares against hand-computed values.
module tb_uart_tx_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*N-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              is_tx = 1'b0;
  logic              transmit;
  logic [7:0]        tx_byte;
  logic              busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N         (N),
    .Ndiv8log2 (2),
    .NREQ      (NREQ)
  ) dut (
    .iCE_CLK         (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .grant           (grant),
    .is_transmitting (is_tx),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .busy            (busy)
  );

  // UART model: not reset by rst, so a byte in flight always completes.
  int byte_time   = 10;
  int start_delay = 0;
  int busy_cnt    = 0;
  int pend_cnt    = 0;
  int dup_cnt     = 0;

  always @(posedge clk) begin
    if (pend_cnt != 0) begin
      if (pend_cnt == 1) begin
        is_tx    <= 1'b1;
        busy_cnt <= byte_time;
      end
      pend_cnt <= pend_cnt - 1;
    end else if (is_tx) begin
      if (busy_cnt <= 1) is_tx <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end
    if (transmit) begin
      if (is_tx || pend_cnt != 0) begin
        dup_cnt <= dup_cnt + 1;
      end else if (start_delay == 0) begin
        is_tx    <= 1'b1;
        busy_cnt <= byte_time;
      end else begin
        pend_cnt <= start_delay;
      end
    end
  end

  // Monitor
  int cyc = 0, fall_cyc = 0, idle_cyc = 0, stab_err = 0;
  logic prev_is_tx = 1'b0, prev_busy = 1'b0;
  logic [7:0] cur_byte = '0;
  logic [7:0]      byte_q[$];
  logic [NREQ-1:0] gnt_q[$];
  logic [NREQ-1:0] rdy_q[$];
  int              tgap_q[$];
  int              rgap_q[$];
  int              bat_q[$];

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    prev_is_tx <= is_tx;
    prev_busy  <= busy;
    if (prev_is_tx && !is_tx) fall_cyc <= cyc;
    if (prev_busy && !busy)   idle_cyc <= cyc;
    if (transmit) begin
      byte_q.push_back(tx_byte);
      gnt_q.push_back(grant);
      tgap_q.push_back(cyc - fall_cyc);
      cur_byte <= tx_byte;
      $display("[%0d] tx byte=%h grant=%b", cyc, tx_byte, grant);
    end
    if (req_ready != '0) begin
      rdy_q.push_back(req_ready);
      rgap_q.push_back(cyc - idle_cyc);
      bat_q.push_back(byte_q.size());
      $display("[%0d] accept req_ready=%b", cyc, req_ready);
    end
    if ((is_tx || pend_cnt != 0) && !transmit && tx_byte != cur_byte)
      stab_err <= stab_err + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rdy(input int total, input int limit);
    int n;
    n = 0;
    while (rdy_q.size() < total && n < limit) begin
      tick();
      n++;
    end
    if (rdy_q.size() < total) check("timeout req_ready", rdy_q.size(), total);
  endtask

  task automatic wait_bytes(input int total, input int limit);
    int n;
    n = 0;
    while (byte_q.size() < total && n < limit) begin
      tick();
      n++;
    end
    if (byte_q.size() < total) check("timeout bytes", byte_q.size(), total);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while ((busy || is_tx) && n < limit) begin
      tick();
      n++;
    end
    if (busy || is_tx) check("timeout idle", {30'd0, busy, is_tx}, 0);
  endtask

  task automatic check_word(input string tag, input int base, input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      check(tag, byte_q[base+i], word[31-8*i -: 8]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, r0, b1, r1, d0, s0, n, cnt0, cnt1;
    logic prev;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst transmit",  transmit,  0);
    check("rst tx_byte",   tx_byte,   0);
    check("rst req_ready", req_ready, 0);
    check("rst grant",     grant,     0);
    check("rst busy",      busy,      0);
    rst = 1'b0;
    tick();
    check("idle no request", {req_ready, busy}, 0);

    // Single word
    b0 = byte_q.size(); r0 = rdy_q.size();
    req_data[31:0] = 32'hDEADBEEF;
    req_valid = 2'b01;
    tick();
    check("t1 req_ready", req_ready, 2'b01);
    check("t1 grant",     grant,     2'b01);
    check("t1 busy",      busy,      1);
    check("t1 no early transmit", transmit, 0);
    req_valid = '0;
    req_data  = '0;
    tick();
    check("t1 transmit", transmit, 1);
    check("t1 tx_byte",  tx_byte,  8'hDE);
    wait_done(500);
    check("t1 byte count", byte_q.size() - b0, 4);
    check_word("t1 byte", b0, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) check("t1 grant at byte", gnt_q[b0+i], 2'b01);
    check("t1 ready count", rdy_q.size() - r0, 1);
    check("t1 grant cleared", grant, 0);
    check("t1 byte spacing", tgap_q[b0+1], 2);

    // Simultaneous requests held from reset
    rst = 1'b1;
    req_data  = {32'hAABBCCDD, 32'h11223344};
    req_valid = 2'b11;
    tick(); tick();
    b0 = byte_q.size(); r0 = rdy_q.size();
    rst = 1'b0;
    wait_rdy(r0 + 2, 500);
    req_valid = '0;
    wait_done(500);
    check("t3 byte count", byte_q.size() - b0, 8);
    check_word("t3 first word",  b0,     32'h11223344);
    check_word("t3 second word", b0 + 4, 32'hAABBCCDD);
    check("t3 first winner",  rdy_q[r0],     2'b01);
    check("t3 second winner", rdy_q[r0 + 1], 2'b10);
    check("t3 ready after idle", rgap_q[r0 + 1], 1);

    // Fairness
    byte_time = 2;
    do_reset();
    b0 = byte_q.size(); r0 = rdy_q.size();
    req_data  = {32'h1A1B1C1D, 32'h0A0B0C0D};
    req_valid = 2'b11;
    wait_rdy(r0 + 8, 3000);
    req_valid = '0;
    wait_done(500);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      check("t4 alternation", rdy_q[r0+i], (i % 2 == 0) ? 2'b01 : 2'b10);
      if (rdy_q[r0+i] == 2'b01) cnt0++;
      if (rdy_q[r0+i] == 2'b10) cnt1++;
    end
    check("t4 ready count 0", cnt0, 4);
    check("t4 ready count 1", cnt1, 4);
    check("t4 byte count", byte_q.size() - b0, 32);
    check_word("t4 word 1", b0 + 4, 32'h1A1B1C1D);

    // Held off while busy
    byte_time = 10;
    do_reset();
    b0 = byte_q.size(); r0 = rdy_q.size();
    req_data[31:0] = 32'h01020304;
    req_valid = 2'b01;
    wait_rdy(r0 + 1, 100);
    req_valid = '0;
    wait_bytes(b0 + 2, 200);
    req_data[63:32] = 32'h55667788;
    req_valid = 2'b10;
    wait_rdy(r0 + 2, 500);
    req_valid = '0;
    wait_done(500);
    check("t5 second winner", rdy_q[r0 + 1], 2'b10);
    check("t5 accept after 4 bytes", bat_q[r0 + 1] - b0, 4);
    check_word("t5 req0 word", b0,     32'h01020304);
    check_word("t5 req1 word", b0 + 4, 32'h55667788);

    // Reset mid-word
    do_reset();
    b0 = byte_q.size();
    req_data[31:0] = 32'hCAFEF00D;
    req_valid = 2'b01;
    wait_bytes(b0 + 2, 200);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6 transmit after rst", transmit, 0);
    check("t6 grant after rst",    grant,    0);
    check("t6 busy after rst",     busy,     0);
    check("t6 uart still busy",    is_tx,    1);
    b1 = byte_q.size(); r1 = rdy_q.size();
    n = 0;
    prev = is_tx;
    while (rdy_q.size() == r1 && n < 200) begin
      prev = is_tx;
      tick();
      n++;
    end
    check("t6 new accept seen", rdy_q.size() - r1, 1);
    check("t6 accept only after uart idle", prev, 0);
    req_valid = '0;
    wait_done(500);
    check("t6 byte count", byte_q.size() - b1, 4);
    check_word("t6 word from MSB", b1, 32'hCAFEF00D);

    // Pulse spacing with a slow-starting UART
    byte_time   = 4;
    start_delay = 3;
    do_reset();
    b0 = byte_q.size(); r0 = rdy_q.size();
    d0 = dup_cnt; s0 = stab_err;
    req_data[31:0] = 32'h13579BDF;
    req_valid = 2'b01;
    wait_rdy(r0 + 1, 100);
    req_valid = '0;
    tick();
    check("t7 transmit", transmit, 1);
    tick();
    check("t7 no repeat pulse", transmit, 0);
    tick();
    check("t7 still held", {transmit, busy}, 2'b01);
    check("t7 tx_byte stable", tx_byte, 8'h13);
    wait_done(800);
    check("t7 byte count", byte_q.size() - b0, 4);
    check_word("t7 word", b0, 32'h13579BDF);
    check("t7 duplicate pulses", dup_cnt - d0, 0);
    check("t7 tx_byte stability", stab_err - s0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
